// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_e;

  typedef enum logic {IDLE, MERGE} state_e;

  // An access faults when its size is illegal or its address is not a
  // multiple of the access width.
  function automatic logic is_misaligned(size_e size, logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lane[0];
      SZ_W:    bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane datapath: builds the merged store word for a sub-word store and
// extracts/extends the load value from a memory word. Purely combinational.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [31:0] shifted;

  // Bring the addressed lane down to bit 0 (little-endian lanes).
  assign shifted = old_word >> {lane, 3'b000};

  // Replace the addressed lane(s) of the old word with the store data.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  // Extend the selected lane to 32 bits, signed or unsigned.
  always_comb begin
    load_val = shifted;
    case (size)
      SZ_B:    load_val = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a word-only data memory. Adds byte and
// halfword access (sub-word stores via read-modify-write), flags misaligned
// accesses and counts completed loads and stores.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready
// are both high. req_* must stay stable while req_valid is high and req_ready
// is low (the pipeline holds them through stall). resp_valid is a one-cycle
// pulse with no backpressure.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic              stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  load_cnt,
  output logic [CNT_W-1:0]  store_cnt,
  output state_e            dbg_state
);

  state_e            state, state_nxt;
  size_e             req_size_e;
  logic              misalign;
  logic              accept;

  logic [ADDR_W-1:0] lat_addr;
  size_e             lat_size;
  logic [31:0]       lat_wdata;
  logic [31:0]       lat_old;

  logic [31:0]       mg_old;
  logic [31:0]       mg_wdata;
  size_e             mg_size;
  logic [1:0]        mg_lane;
  logic [31:0]       merged;
  logic [31:0]       load_val;

  assign req_size_e = size_e'(req_size);
  assign misalign   = is_misaligned(req_size_e, req_addr[1:0]);
  assign stall      = ~req_ready & req_valid;
  assign dbg_state  = state;

  // In MERGE the lane datapath works on the latched store; otherwise it
  // extracts the load value straight from the memory read word.
  assign mg_old   = (state == MERGE) ? lat_old   : mem_rdata;
  assign mg_wdata = (state == MERGE) ? lat_wdata : req_wdata;
  assign mg_size  = (state == MERGE) ? lat_size  : req_size_e;
  assign mg_lane  = (state == MERGE) ? lat_addr[1:0] : req_addr[1:0];

  mem_lane_merge u_lane (
    .old_word (mg_old),
    .wdata    (mg_wdata),
    .size     (mg_size),
    .lane     (mg_lane),
    .sign_ext (req_signed),
    .merged   (merged),
    .load_val (load_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and memory-side controls; rst_n gates the strobes so a write
  // in flight is abandoned the moment reset asserts.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        accept    = req_valid & rst_n;
        if (accept && req_write && !misalign) begin
          if (req_size_e == SZ_W) mem_we    = 1'b1;
          else                    state_nxt = MERGE;
        end
      end
      MERGE: begin
        mem_we    = rst_n;
        mem_addr  = lat_addr;
        mem_wdata = merged;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response pulse, sub-word store latch and saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      load_cnt      <= '0;
      store_cnt     <= '0;
      lat_addr      <= '0;
      lat_size      <= SZ_B;
      lat_wdata     <= '0;
      lat_old       <= '0;
    end else begin
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
      if (state == MERGE) begin
        resp_valid <= 1'b1;
        if (store_cnt != '1) store_cnt <= store_cnt + CNT_W'(1);
      end else if (accept) begin
        if (misalign) begin
          resp_valid    <= 1'b1;
          resp_misalign <= 1'b1;
        end else if (!req_write) begin
          resp_valid <= 1'b1;
          resp_rdata <= load_val;
          if (load_cnt != '1) load_cnt <= load_cnt + CNT_W'(1);
        end else if (req_size_e == SZ_W) begin
          resp_valid <= 1'b1;
          if (store_cnt != '1) store_cnt <= store_cnt + CNT_W'(1);
        end else begin
          lat_addr  <= req_addr;
          lat_size  <= req_size_e;
          lat_wdata <= req_wdata;
          lat_old   <= mem_rdata;
        end
      end
    end
  end

endmodule
